// File: rtl/tug_input_conditioner_if.sv
// Pushbutton-side signal bundle for the tug input conditioner.
//   KEY_L, KEY_R : raw asynchronous active-low pushbuttons (0 = pressed)
//   Enable       : when 0, accepted presses produce no pulse
//   L, R         : registered single-cycle press pulses
// master drives keys/enable and receives pulses; slave is the conditioner.
interface tug_input_conditioner_if;
    logic KEY_L;
    logic KEY_R;
    logic Enable;
    logic L;
    logic R;

    modport master (
        output KEY_L,
        output KEY_R,
        output Enable,
        input  L,
        input  R
    );

    modport slave (
        input  KEY_L,
        input  KEY_R,
        input  Enable,
        output L,
        output R
    );
endinterface

// File: rtl/tug_input_conditioner.sv
// Tug-of-war pushbutton conditioner: synchronizes and debounces two
// active-low keys and emits one registered pulse per accepted press.
//   clk   : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : tug_input_conditioner_if.slave (KEY_L, KEY_R, Enable in; L, R out)
// Parameter DEBOUNCE_CYCLES (2..65535): consecutive stable samples needed to
// accept a press or a release.

// One debounced channel: 2-flop synchronizer plus press/release FSM.
//   key_n  : raw active-low key
//   enable : gates the pulse on the acceptance edge only
//   pulse  : registered single-cycle press pulse
module tug_key_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic key_n,
    input  logic enable,
    output logic pulse
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    logic [1:0]    sync;
    logic          pressed;
    state_t        state;
    logic [CW-1:0] count;

    // Resets to released so a key held through reset is seen as a new press.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign pressed = ~sync[1];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            count <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_CHK;
                        count <= ONE;
                    end else begin
                        count <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!pressed) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == LAST) begin
                        // Press is consumed here whether or not Enable lets it out.
                        state <= HELD;
                        count <= '0;
                        pulse <= enable;
                    end else begin
                        count <= count + ONE;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state <= RELEASE_CHK;
                        count <= ONE;
                    end
                end
                RELEASE_CHK: begin
                    if (pressed) begin
                        state <= HELD;
                        count <= '0;
                    end else if (count == LAST) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end
endmodule

module tug_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic                    clk,
    input logic                    Reset,
    tug_input_conditioner_if.slave bus
);
    logic pulse_l;
    logic pulse_r;

    tug_key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk    (clk),
        .Reset  (Reset),
        .key_n  (bus.KEY_L),
        .enable (bus.Enable),
        .pulse  (pulse_l)
    );

    tug_key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk    (clk),
        .Reset  (Reset),
        .key_n  (bus.KEY_R),
        .enable (bus.Enable),
        .pulse  (pulse_r)
    );

    // No arbitration: simultaneous acceptance drives both pulses together.
    assign bus.L = pulse_l;
    assign bus.R = pulse_r;
endmodule

// File: tb/tb_tug_input_conditioner.sv
// Bench for tug_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_tug_input_conditioner;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic Reset;

    tug_input_conditioner_if bus ();

    tug_input_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lp_cnt = 0;
    int rp_cnt = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a key level becomes accepted after D consecutive
    // samples that differ from the currently accepted level; samples reach
    // the decision two edges after the raw input; reset means released.
    bit dl[2][2];
    bit acc[2];
    int run[2];
    bit raw[2];
    bit smp;
    logic [1:0] e;

    always @(posedge clk) begin
        e = '0;
        raw[0] = bus.KEY_L;
        raw[1] = bus.KEY_R;
        for (int c = 0; c < 2; c++) begin
            if (!Reset) begin
                dl[c][0] = 1'b1;
                dl[c][1] = 1'b1;
                acc[c]   = 1'b0;
                run[c]   = 0;
            end else begin
                smp = dl[c][1];
                dl[c][1] = dl[c][0];
                dl[c][0] = raw[c];
                if ((smp == 1'b0) != acc[c]) begin
                    run[c]++;
                    if (run[c] == int'(D)) begin
                        acc[c] = (smp == 1'b0);
                        run[c] = 0;
                        if (acc[c] && bus.Enable) e[c] = 1'b1;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: compares the DUT outputs after each edge with the scoreboard.
    logic [1:0] got_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got no expected entry at %0t", $time);
        end else begin
            got_e = exp_q.pop_front();
            check("L", int'(bus.L), int'(got_e[0]));
            check("R", int'(bus.R), int'(got_e[1]));
        end
        if (bus.L) lp_cnt++;
        if (bus.R) rp_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic kl, input logic kr, input logic en);
        @(negedge clk);
        bus.KEY_L  = kl;
        bus.KEY_R  = kr;
        bus.Enable = en;
    endtask

    // Waits n edges; returns index of first edge after which the selected
    // output was high (-1 if none). Call right after a negedge.
    task automatic watch(input int n, input bit sel_r, output int first);
        first = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (((sel_r ? bus.R : bus.L) == 1'b1) && first < 0) first = i;
        end
    endtask

    int l0, r0, fl, fr;
    bit got;
    int left_len, right_len;
    logic kl, kr;

    initial begin
        Reset      = 1'b0;
        bus.KEY_L  = 1'b1;
        bus.KEY_R  = 1'b1;
        bus.Enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_L", int'(bus.L), 0);
        check("rst_R", int'(bus.R), 0);
        Reset = 1'b1;
        repeat (6) @(negedge clk);

        // Clean press
        l0 = lp_cnt; r0 = rp_cnt;
        bus.KEY_L = 1'b0;
        watch(20, 1'b0, fl);
        check("clean_latency", fl, 5);
        check("clean_count", lp_cnt - l0, 1);
        check("clean_R", rp_cnt - r0, 0);
        drive(1, 1, 1);
        repeat (8) @(negedge clk);

        // Glitch, then a real press
        r0 = rp_cnt;
        bus.KEY_R = 1'b0;
        repeat (3) @(negedge clk);
        bus.KEY_R = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_R", rp_cnt - r0, 0);
        bus.KEY_R = 1'b0;
        repeat (10) @(negedge clk);
        bus.KEY_R = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_then_press_R", rp_cnt - r0, 1);

        // Release bounce
        l0 = lp_cnt;
        bus.KEY_L = 1'b0;
        repeat (8) @(negedge clk);
        bus.KEY_L = 1'b1; @(negedge clk);
        bus.KEY_L = 1'b0; @(negedge clk);
        bus.KEY_L = 1'b1; @(negedge clk);
        bus.KEY_L = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_single", lp_cnt - l0, 1);
        bus.KEY_L = 1'b1;
        repeat (6) @(negedge clk);
        bus.KEY_L = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_repress", lp_cnt - l0, 2);
        bus.KEY_L = 1'b1;
        repeat (8) @(negedge clk);

        // Simultaneous press
        bus.KEY_L = 1'b0;
        bus.KEY_R = 1'b0;
        fork
            watch(12, 1'b0, fl);
            watch(12, 1'b1, fr);
        join
        check("sim_L", fl, 5);
        check("sim_R", fr, 5);
        drive(1, 1, 1);
        repeat (8) @(negedge clk);

        // Enable gating
        l0 = lp_cnt;
        bus.Enable = 1'b0;
        bus.KEY_L  = 1'b0;
        repeat (10) @(negedge clk);
        bus.Enable = 1'b1;
        repeat (10) @(negedge clk);
        check("enable_gate", lp_cnt - l0, 0);
        bus.KEY_L = 1'b1;
        repeat (8) @(negedge clk);

        // Reset mid-check
        l0 = lp_cnt;
        bus.KEY_L = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        #1;
        check("rst_midchk_L", int'(bus.L), 0);
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        watch(12, 1'b0, fl);
        check("rst_midchk_latency", fl, 5);
        check("rst_midchk_count", lp_cnt - l0, 1);
        drive(1, 1, 1);
        repeat (8) @(negedge clk);

        // Reset mid-pulse, key held through reset
        bus.KEY_L = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #2;
            if (bus.L) got = 1'b1;
        end
        check("midpulse_seen", int'(got), 1);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check("rst_midpulse_L", int'(bus.L), 0);
        repeat (2) @(negedge clk);
        l0 = lp_cnt;
        Reset = 1'b1;
        repeat (12) @(negedge clk);
        check("held_thru_rst", lp_cnt - l0, 1);
        drive(1, 1, 1);
        repeat (8) @(negedge clk);

        // Randomized run lengths, occasional Enable drops and resets
        left_len = 0; right_len = 0;
        kl = 1'b1; kr = 1'b1;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            if (left_len == 0) begin
                kl = ~kl;
                left_len = int'($urandom_range(1, 7));
            end
            if (right_len == 0) begin
                kr = ~kr;
                right_len = int'($urandom_range(1, 7));
            end
            left_len--;
            right_len--;
            bus.KEY_L  = kl;
            bus.KEY_R  = kr;
            bus.Enable = ($urandom_range(0, 9) != 0);
            Reset      = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        Reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
